// File: rtl/sync_pattern_pkg.sv
// Shared constants, state type and sync-word lookup for the sync pattern transmitter.
package sync_pattern_pkg;

  localparam int unsigned SYNC_LEN   = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1011;
  localparam int unsigned SYNC_IDX_W = $clog2(SYNC_LEN);
  localparam int unsigned HIST_W     = 3;
  // History that forces a stuff bit: the next bit would otherwise be able to complete 1011.
  localparam logic [HIST_W-1:0] STUFF_PAT = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    GAP
  } state_e;

  function automatic logic sync_bit(input logic [SYNC_IDX_W-1:0] idx);
    logic [SYNC_IDX_W-1:0] pos;
    pos = SYNC_IDX_W'(SYNC_LEN - 1) - idx;
    return SYNC_WORD[pos];
  endfunction

endpackage

// File: rtl/stuff_tracker.sv
// Tracks the last three payload-line bits and flags when a stuff bit must be inserted.
module stuff_tracker
  import sync_pattern_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic stuff_req
);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic              stuff_q;

  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (shift_en) begin
      hist_d = {hist_q[HIST_W-2:0], bit_in};
    end
  end

  // Flag is registered from the next history so it lines up with the bit now on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      stuff_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      stuff_q <= (hist_d == STUFF_PAT);
    end
  end

  assign stuff_req = stuff_q;

endmodule

// File: rtl/sync_pattern_tx.sv
// Serial frame transmitter: sync word 1011, bit-stuffed payload MSB first, one gap cycle.
module sync_pattern_tx
  import sync_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              frame_active,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e                  state_q, state_d;
  logic [SYNC_IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       sh_q, sh_d;
  logic                    ser_q, ser_d;
  logic                    act_q, act_d;
  logic                    done_q, done_d;
  logic                    rdy_q, rdy_d;
  logic                    clr_c, shen_c, stuff_req_c;

  stuff_tracker u_stuff (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr_c),
    .shift_en (shen_c),
    .bit_in   (ser_d),
    .stuff_req(stuff_req_c)
  );

  // Next-state logic: registered outputs describe the bit that will be on the line next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ser_d   = 1'b0;
    act_d   = 1'b0;
    done_d  = 1'b0;
    rdy_d   = 1'b0;
    clr_c   = 1'b0;
    shen_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (tx_valid && rdy_q) begin
          state_d = SYNC;
          idx_d   = '0;
          cnt_d   = '0;
          sh_d    = tx_data;
          ser_d   = sync_bit('0);
          act_d   = 1'b1;
          rdy_d   = 1'b0;
          clr_c   = 1'b1;
        end
      end
      SYNC: begin
        act_d = 1'b1;
        if (idx_q == SYNC_IDX_W'(SYNC_LEN - 1)) begin
          state_d = DATA;
          ser_d   = sh_q[DATA_W-1];
          sh_d    = sh_q << 1;
          cnt_d   = CNT_W'(1);
          shen_c  = 1'b1;
        end else begin
          idx_d = idx_q + SYNC_IDX_W'(1);
          ser_d = sync_bit(idx_q + SYNC_IDX_W'(1));
        end
      end
      DATA, STUFF: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = GAP;
          done_d  = 1'b1;
        end else if (stuff_req_c) begin
          state_d = STUFF;
          act_d   = 1'b1;
          shen_c  = 1'b1;
        end else begin
          state_d = DATA;
          act_d   = 1'b1;
          ser_d   = sh_q[DATA_W-1];
          sh_d    = sh_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          shen_c  = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      act_q   <= act_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx_ready     = rdy_q;
  assign serial_out   = ser_q;
  assign frame_active = act_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sync_pattern_tx.sv
// Scoreboard bench for sync_pattern_tx: random frames against a bit-list reference model.
module tb_sync_pattern_tx;

  localparam int unsigned DATA_W = 8;
  localparam time         PERIOD = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              serial_out;
  logic              frame_active;
  logic              done;

  sync_pattern_tx #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .serial_out  (serial_out),
    .frame_active(frame_active),
    .done        (done)
  );

  always #(PERIOD / 2) clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  time        start_q[$];
  int         len_q[$];

  bit         mon_en      = 1'b0;
  logic       prev_act    = 1'b0;
  logic       prev_done   = 1'b0;
  int         zero_run    = 0;
  int         last_gap    = -1;
  int         frames_seen = 0;
  int         frame_idx   = 0;
  int         detects     = 0;
  int         frames_done = 0;
  logic [3:0] det_sh      = 4'b0;
  logic [2:0] mon_e;
  time        mon_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference frame: sync word, then payload with a 0 inserted whenever the last three sent were 1,0,1.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic       sent[$];
    logic [3:0] sw;
    int         n;
    sw = 4'b1011;
    for (int i = 3; i >= 0; i--) exp_q.push_back({sw[i], 2'b10});
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      n = sent.size();
      if (n >= 3 && sent[n-3] == 1'b1 && sent[n-2] == 1'b0 && sent[n-1] == 1'b1) begin
        sent.push_back(1'b0);
        exp_q.push_back(3'b010);
      end
      sent.push_back(d[i]);
      exp_q.push_back({d[i], 2'b10});
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit track);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!tx_ready) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = DATA_W'($urandom);
      budget++;
      if (budget > 200) begin
        check("ready_timeout", 32'd0, 32'd1);
        return;
      end
      @(negedge clk);
    end
    tx_valid = 1'b1;
    tx_data  = d;
    if (track) begin
      push_frame(d);
      start_q.push_back($time + PERIOD);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = DATA_W'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      idle(1);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      start_q.delete();
    end
    idle(2);
  endtask

  // Monitor: scoreboard pop on every frame/gap cycle, plus a 1011 non-overlapping detector on the line.
  always @(negedge clk) begin
    if (mon_en) begin
      det_sh = {det_sh[2:0], serial_out};
      if (frame_active && !prev_act) begin
        if (start_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          mon_t = start_q.pop_front();
          check("start_time", 32'($time), 32'(mon_t));
        end
        if (frames_seen > 0) begin
          check("gap_min", 32'(zero_run >= 2), 32'd1);
          last_gap = zero_run;
        end
        frames_seen++;
        frame_idx = 0;
      end
      if (frame_active || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'({serial_out, frame_active, done}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("line", 32'({serial_out, frame_active, done}), 32'(mon_e));
          check("ready_busy", 32'(tx_ready), 32'd0);
        end
      end else begin
        check("idle_serial", 32'(serial_out), 32'd0);
      end
      if (det_sh == 4'b1011) begin
        detects++;
        det_sh = 4'b0;
        check("detect_pos", 32'(frame_idx), 32'd3);
      end
      if (frame_active) begin
        frame_idx++;
        zero_run = 0;
      end else begin
        zero_run++;
      end
      if (done) begin
        len_q.push_back(frame_idx);
        frames_done++;
      end
      if (prev_done) check("ready_after_gap", 32'(tx_ready), 32'd1);
      prev_act  = frame_active;
      prev_done = done;
    end else begin
      prev_act    = 1'b0;
      prev_done   = 1'b0;
      zero_run    = 0;
      frames_seen = 0;
      det_sh      = 4'b0;
    end
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_len[3];
    int got_len;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_serial", 32'(serial_out), 32'd0);
    check("rst_active", 32'(frame_active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(tx_ready), 32'd1);
    mon_en = 1'b1;

    send(8'h00, 1'b1); drain();
    send(8'hA0, 1'b1); drain();
    send(8'hBF, 1'b1); drain();
    exp_len[0] = 12; exp_len[1] = 13; exp_len[2] = 17;
    for (int i = 0; i < 3; i++) begin
      got_len = (len_q.size() > 0) ? len_q.pop_front() : -1;
      check("frame_len", 32'(got_len), 32'(exp_len[i]));
    end

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drain();
    check("b2b_gap", 32'(last_gap), 32'd2);
    len_q.delete();

    repeat (40) begin
      send(DATA_W'($urandom), 1'b1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
    end
    drain();
    check("frames_done", 32'(frames_done), 32'd45);
    check("detects", 32'(detects), 32'(frames_done));

    // Mid-frame reset during the third payload bit of 8'hA0.
    mon_en = 1'b0;
    send(8'hA0, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_pre_bit", 32'({serial_out, frame_active}), 32'b11);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out", 32'({serial_out, frame_active, done, tx_ready}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(tx_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_resume", 32'({serial_out, frame_active, done}), 32'd0);
    end

    mon_en = 1'b1;
    send(8'hA5, 1'b1);
    drain();
    check("post_abort_frames", 32'(frames_done), 32'd46);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
